rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Parametrised reset controller for the SoC top level. It replaces the fixed single-output button reset generator.
//  Merges power-on, debounced push-button, software and optional watchdog reset sources.
//  Drives NUM_DOMAINS synchronous, active-high reset outputs: all assert together, then release in staggered order.
//  Latches the cause of the last reset for software readback.
// PARAMETERS
//  NUM_DOMAINS     3      number of reset outputs; domain 0 releases first (bus/clock infra), then 1, 2...
//  SYNC_STAGES     2      synchroniser depth for rst_btn_n (>=2)
//  DEBOUNCE_CYCLES 50000  consecutive stable cycles to accept a button level change (1 ms at 50 MHz)
//  HOLD_CYCLES     1024   minimum cycles all outputs stay asserted after any reset event
//  STAGGER_CYCLES  16     cycles between successive domain releases
//  WDT_CYCLES      2**24  watchdog timeout; used only with RST_SEQ_WDT_EN
// PORTS
//  clock       in   1            system clock
//  reset       in   1            asynchronous active-high raw reset (power-on); treated as POR cause
//  rst_btn_n   in   1            asynchronous active-low push button
//  sw_rst_req  in   1            single-cycle software reset request, synchronous to clock
//  wdt_kick    in   1            watchdog restart pulse (ignored without RST_SEQ_WDT_EN)
//  rst_out     out  NUM_DOMAINS  active-high per-domain resets, deasserted synchronously
//  rst_cause   out  2            0=POR 1=BUTTON 2=SOFTWARE 3=WATCHDOG; cause of latest reset
//  busy        out  1            high while any rst_out bit is high
// BEHAVIOUR
//  - While reset=1: rst_out all 1s, rst_cause=0, busy=1, state HOLD, counters cleared, synchroniser preset to 1.
//  - Outputs assert asynchronously only via reset. All other assertion and all deassertion occur on clock edges.
//  - Button path: SYNC_STAGES flops feed a debouncer.
//    - Debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
//    - A press event is a debounced 1->0 transition.
//  - FSM states: HOLD, RELEASE, RUN.
//  - HOLD:
//    - rst_out all 1s.
//    - Counter runs to HOLD_CYCLES-1.
//    - Exit to RELEASE only when the counter has expired AND the debounced button is released (high).
//    - A long press therefore extends reset.
//  - RELEASE:
//    - rst_out[0] clears on the HOLD->RELEASE edge.
//    - rst_out[i] clears STAGGER_CYCLES after rst_out[i-1].
//    - Enter RUN on the cycle the last bit clears.
//    - NUM_DOMAINS=1 goes HOLD->RUN directly.
//  - RUN: rst_out all 0s, busy=0.
//  - Reset event = button press | sw_rst_req | watchdog expiry.
//    - In RUN or RELEASE: next edge sets rst_out all 1s, enters HOLD, clears the counter and latches rst_cause.
//    - In HOLD: sw_rst_req and watchdog events are ignored; rst_cause is unchanged.
//  - Simultaneous events, cause priority: WATCHDOG > BUTTON > SOFTWARE.
//  - POR timing: with reset low before edge 1, rst_out[i] is first low after edge HOLD_CYCLES + i*STAGGER_CYCLES + 1 (button idle).
//  - Counter widths: $clog2(max count + 1). No wrap: each counter saturates at its terminal value.
// CONFIGURATION
//  RST_SEQ_WDT_EN defined:
//    - WDT_CYCLES down-counter, reloaded on wdt_kick and held at reload while state != RUN.
//    - Reaching 0 in RUN is a watchdog reset event (cause 3).
//  RST_SEQ_WDT_EN undefined:
//    - No watchdog logic; wdt_kick unused; cause 3 is never produced.
// STRUCTURE
//  - rst_seq_pkg: enum rst_cause_e (POR/BUTTON/SOFTWARE/WATCHDOG, 2 bits); enum rst_state_e (HOLD/RELEASE/RUN).
//  - Sub-module rst_btn_debounce (params SYNC_STAGES, DEBOUNCE_CYCLES) containing synchroniser, debouncer and press-event output.
//  - FSM, stagger counter and watchdog stay in rst_seq_ctrl.
// TESTING  (NUM_DOMAINS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, STAGGER_CYCLES=3, WDT_CYCLES=20)
//  1. POR: reset high 5 cycles then low, button high
//     -> rst_out[0] low after edge 9, [1] after 12, [2] after 15; busy low with [2]; rst_cause=0.
//  2. Glitch: in RUN, rst_btn_n low 3 cycles -> no reset event, rst_out stays 000.
//  3. Long press: rst_btn_n low 30 cycles
//     -> rst_out=111 ~DEBOUNCE+SYNC cycles after fall, cause=1;
//     -> hold persists until debounced release plus remaining HOLD, then staggered release.
//  4. sw_rst_req pulse in RELEASE (after rst_out[0] clears) -> next edge rst_out=111, cause=2, full sequence restarts.
//  5. Same-cycle sw_rst_req and button press event in RUN -> cause=1; second sw_rst_req during HOLD ignored.
//  6. RST_SEQ_WDT_EN, no kicks in RUN
//     -> rst_out=111 20 cycles after entering RUN, cause=3.
//     With kicks every 10 cycles -> no reset. Undefined build -> no reset ever.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared reset-cause and sequencer state encodings
package rst_seq_pkg;
  typedef enum logic [1:0] {CAUSE_POR, CAUSE_BUTTON, CAUSE_SOFTWARE, CAUSE_WATCHDOG} rst_cause_e;
  typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN} rst_state_e;
endpackage

// File: rtl/rst_btn_debounce.sv
// rst_btn_debounce: push-button synchroniser, debouncer and press-event detector
module rst_btn_debounce
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip  = sync[SYNC_STAGES-1] != level && cnt == CMAX;
  assign press = flip && level;
  // Count consecutive samples disagreeing with the accepted level; flip once the run is long enough
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn_n};
      cnt   <= (sync[SYNC_STAGES-1] == level || flip) ? '0 : cnt + CW'(1);
      level <= flip ? ~level : level;
    end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: multi-source reset controller with staggered per-domain release (RST_SEQ_WDT_EN adds a watchdog)
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int STAGGER_CYCLES  = 16,
  parameter int WDT_CYCLES      = 2**24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rst_btn_n,
  input  logic                   sw_rst_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic [1:0]             rst_cause,
  output logic                   busy
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = STAGGER_CYCLES > 1 ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(STAGGER_CYCLES - 1);
  rst_state_e state, state_n;
  rst_cause_e cause, cause_n, event_cause;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [NUM_DOMAINS-1:0] out_n, shl;
  logic armed, btn_level, press, wdog, expired, event_hit;
  rst_btn_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock(clock),
    .reset(reset),
    .btn_n(rst_btn_n),
    .level(btn_level),
    .press(press)
  );
`ifdef RST_SEQ_WDT_EN
  localparam int WW = WDT_CYCLES > 1 ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WW-1:0] WMAX = WW'(WDT_CYCLES - 1);
  logic [WW-1:0] wdt;
  assign wdog = state == ST_RUN && wdt == '0;
  // Watchdog only runs in RUN; kicks and every other state keep it at the reload value
  always_ff @(posedge clock or posedge reset)
    if (reset) wdt <= WMAX;
    else wdt <= (wdt_kick || state != ST_RUN) ? WMAX : (wdt == '0 ? wdt : wdt - WW'(1));
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign wdog = 1'b0;
`endif
  assign shl         = rst_out << 1;
  assign expired     = armed && hcnt == HMAX;
  assign event_hit   = wdog || press || sw_rst_req;
  assign event_cause = wdog ? CAUSE_WATCHDOG : press ? CAUSE_BUTTON : CAUSE_SOFTWARE;
  assign rst_cause   = cause;
  assign busy        = |rst_out;
  // Sequencer registers; armed delays the hold count one cycle to synchronise raw reset release
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= ST_HOLD;
      cause   <= CAUSE_POR;
      hcnt    <= '0;
      scnt    <= '0;
      rst_out <= '1;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      cause   <= cause_n;
      hcnt    <= hcnt_n;
      scnt    <= scnt_n;
      rst_out <= out_n;
      armed   <= 1'b1;
    end
  // Next state: hold until timed out with the button up, then clear the lowest still-set domain every stagger period
  always_comb begin
    state_n = state;
    cause_n = cause;
    hcnt_n  = hcnt;
    scnt_n  = scnt;
    out_n   = rst_out;
    case (state)
      ST_HOLD: begin
        out_n = '1;
        if (press) begin
          hcnt_n  = '0;
          cause_n = CAUSE_BUTTON;
        end else if (expired && btn_level) begin
          out_n   = shl;
          scnt_n  = '0;
          state_n = shl == '0 ? ST_RUN : ST_RELEASE;
        end else if (armed && !expired) hcnt_n = hcnt + HW'(1);
      end
      default: begin
        if (event_hit) begin
          state_n = ST_HOLD;
          cause_n = event_cause;
          hcnt_n  = '0;
          out_n   = '1;
        end else if (state == ST_RELEASE) begin
          scnt_n = scnt == SMAX ? '0 : scnt + SW'(1);
          if (scnt == SMAX) begin
            out_n   = shl;
            state_n = shl == '0 ? ST_RUN : ST_RELEASE;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench for rst_seq_ctrl against a timeline-based reference model
module tb_rst_seq_ctrl;
  localparam int N = 3, SYNC = 2, DEB = 4, HOLD = 8, STAG = 3, WDT = 20;
  logic clock = 1'b0, reset = 1'b0, rst_btn_n = 1'b1, sw_rst_req = 1'b0, wdt_kick = 1'b0;
  logic [N-1:0] rst_out;
  logic [1:0] rst_cause;
  logic busy;
  typedef struct packed {
    logic [N-1:0] ro;
    logic [1:0]   cause;
    logic         busy;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, passes = 0;
  int k, t_event, rel_t, wdt_ref;
  bit in_hold, lvl;
  bit raw_q[$];
  bit win[$];
  logic [1:0] m_cause;

  rst_seq_ctrl #(
    .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .WDT_CYCLES(WDT)
  ) dut (
    .clock(clock), .reset(reset), .rst_btn_n(rst_btn_n), .sw_rst_req(sw_rst_req),
    .wdt_kick(wdt_kick), .rst_out(rst_out), .rst_cause(rst_cause), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_init();
    k = 0; t_event = 1; rel_t = 0; wdt_ref = 0;
    in_hold = 1'b1; lvl = 1'b1; m_cause = 2'd0;
    raw_q.delete(); win.delete(); exp_q.delete();
    repeat (SYNC) raw_q.push_back(1'b1);
    repeat (DEB) win.push_back(1'b1);
  endtask

  // Reference: outputs derived from when hold began and when release began, per spec timing rules
  task automatic model_step();
    bit s, flip, press, lvl_pre, running, wdog;
    exp_t me;
    k++;
    raw_q.push_back(rst_btn_n);
    s = raw_q.pop_front();
    win.push_back(s);
    void'(win.pop_front());
    flip = 1'b1;
    foreach (win[i]) if (win[i] == lvl) flip = 1'b0;
    press = flip && lvl;
    lvl_pre = lvl;
    if (flip) lvl = ~lvl;
    running = !in_hold && (k - 1 - rel_t) >= (N - 1) * STAG;
    wdog = 1'b0;
`ifdef RST_SEQ_WDT_EN
    wdog = running && (k - wdt_ref) >= WDT;
    if (wdt_kick || !running) wdt_ref = k;
`endif
    if (in_hold) begin
      if (press) begin
        t_event = k;
        m_cause = 2'd1;
      end else if (k - t_event >= HOLD && lvl_pre) begin
        in_hold = 1'b0;
        rel_t = k;
      end
    end else if (wdog || press || sw_rst_req) begin
      in_hold = 1'b1;
      t_event = k;
      m_cause = wdog ? 2'd3 : press ? 2'd1 : 2'd2;
    end
    for (int i = 0; i < N; i++) me.ro[i] = in_hold || (k - rel_t) < i * STAG;
    me.cause = m_cause;
    me.busy = |me.ro;
    exp_q.push_back(me);
  endtask

  initial forever begin
    @(posedge clock);
    if (reset) model_init();
    else model_step();
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {rst_out, rst_cause, busy}, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
  endtask

  task automatic wait_out(input logic [N-1:0] t, input string name);
    int n = 0;
    while (n < 200 && rst_out !== t) begin
      cyc(1);
      n++;
    end
    check(name, rst_out, t);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check("async_rst_out", rst_out, 3'b111);
    check("async_busy", busy, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    check("por_rst_out", rst_out, 3'b111);
    check("por_cause", rst_cause, 2'd0);
    reset = 1'b0;
    cyc(25);
    check("por_run", rst_out, 3'b000);
    check("por_run_cause", rst_cause, 2'd0);
    rst_btn_n = 1'b0;
    cyc(DEB - 1);
    rst_btn_n = 1'b1;
    cyc(15);
    check("glitch", rst_out, 3'b000);
    rst_btn_n = 1'b0;
    cyc(30);
    check("long_press_hold", rst_out, 3'b111);
    check("long_press_cause", rst_cause, 2'd1);
    rst_btn_n = 1'b1;
    wait_out(3'b110, "release_d0");
    pulse_sw();
    check("sw_in_release", rst_out, 3'b111);
    check("sw_cause", rst_cause, 2'd2);
    wait_out(3'b000, "sw_run");
    cyc(3);
    rst_btn_n = 1'b0;
    cyc(SYNC + DEB - 1);
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    check("both_cause", rst_cause, 2'd1);
    cyc(3);
    pulse_sw();
    check("sw_in_hold_ignored", rst_cause, 2'd1);
    cyc(5);
    rst_btn_n = 1'b1;
    wait_out(3'b000, "both_run");
`ifdef RST_SEQ_WDT_EN
    cyc(25);
    check("wdt_cause", rst_cause, 2'd3);
    wait_out(3'b000, "wdt_run");
    for (int i = 0; i < 6; i++) begin
      wdt_kick = 1'b1;
      cyc(1);
      wdt_kick = 1'b0;
      cyc(9);
    end
    check("wdt_kicked", rst_out, 3'b000);
`else
    cyc(60);
    check("no_wdt", rst_out, 3'b000);
    check("no_wdt_cause", rst_cause, 2'd1);
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rst_btn_n = ~rst_btn_n;
      sw_rst_req = $urandom_range(0, 29) == 0;
      wdt_kick = $urandom_range(0, 7) == 0;
      cyc(1);
    end
    rst_btn_n = 1'b1;
    sw_rst_req = 1'b0;
    wdt_kick = 1'b0;
    cyc(60);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_out", rst_out, 3'b111);
    check("mid_rst_cause", rst_cause, 2'd0);
    check("mid_rst_busy", busy, 1'b1);
    cyc(2);
    reset = 1'b0;
    cyc(25);
    check("final_run", rst_out, 3'b000);
    check("final_busy", busy, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
